// File: rtl/loop_address_generator_if.sv
// Address stream channel: producer drives valid/addr/last, consumer drives ready.
// A beat transfers on a rising edge where valid and ready are both high.
interface loop_address_generator_if #(
    parameter int unsigned AddrWidth = 16
) ();
    logic                 valid;
    logic                 ready;
    logic [AddrWidth-1:0] addr;
    logic                 last;

    modport master (output valid, output addr, output last, input ready);
    modport slave  (input valid, input addr, input last, output ready);
endinterface

// File: rtl/loop_address_generator.sv
// Two-level nested-loop address generator: walks columns 0..InnerMax inside rows 0..OuterMax
// and streams RowBase + i over a valid/ready channel, ending each run with a one-cycle Done.
module loop_address_generator #(
    parameter int unsigned CounterWidth = 4,
    parameter int unsigned AddrWidth    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CounterWidth-1:0] inner_max_i,
    input  logic [CounterWidth-1:0] outer_max_i,
    input  logic [AddrWidth-1:0]    base_addr_i,
    input  logic [AddrWidth-1:0]    row_stride_i,
    output logic                    busy_o,
    output logic                    done_o,
    loop_address_generator_if.master addr_if
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CounterWidth-1:0] i_q, i_d, j_q, j_d;
    logic [CounterWidth-1:0] inner_max_q, inner_max_d, outer_max_q, outer_max_d;
    logic [AddrWidth-1:0]    row_base_q, row_base_d, row_stride_q, row_stride_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic                    valid_q, valid_d, last_q, last_d;
    logic                    busy_q, busy_d, done_q, done_d;

    logic                    xfer;
    logic [CounterWidth-1:0] i_inc, j_inc;
    logic [AddrWidth-1:0]    next_row_base;

    assign xfer          = valid_q && addr_if.ready;
    assign i_inc         = i_q + 1'b1;
    assign j_inc         = j_q + 1'b1;
    assign next_row_base = row_base_q + row_stride_q;

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        inner_max_d  = inner_max_q;
        outer_max_d  = outer_max_q;
        row_base_d   = row_base_q;
        row_stride_d = row_stride_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        last_d       = last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        if (clear_i) begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d      = StRun;
                        inner_max_d  = inner_max_i;
                        outer_max_d  = outer_max_i;
                        row_stride_d = row_stride_i;
                        row_base_d   = base_addr_i;
                        addr_d       = base_addr_i;
                        i_d          = '0;
                        j_d          = '0;
                        valid_d      = 1'b1;
                        busy_d       = 1'b1;
                        last_d       = (inner_max_i == '0) && (outer_max_i == '0);
                    end
                end
                StRun: begin
                    if (xfer) begin
                        if (last_q) begin
                            state_d = StDone;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (i_q == inner_max_q) begin
                            // Row wrap: the next address is the freshly accumulated row base.
                            i_d        = '0;
                            j_d        = j_inc;
                            row_base_d = next_row_base;
                            addr_d     = next_row_base;
                            last_d     = (inner_max_q == '0) && (j_inc == outer_max_q);
                        end else begin
                            i_d    = i_inc;
                            addr_d = addr_q + 1'b1;
                            last_d = (i_inc == inner_max_q) && (j_q == outer_max_q);
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            i_q          <= '0;
            j_q          <= '0;
            inner_max_q  <= '0;
            outer_max_q  <= '0;
            row_base_q   <= '0;
            row_stride_q <= '0;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            inner_max_q  <= inner_max_d;
            outer_max_q  <= outer_max_d;
            row_base_q   <= row_base_d;
            row_stride_q <= row_stride_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign addr_if.valid = valid_q;
    assign addr_if.addr  = addr_q;
    assign addr_if.last  = last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_loop_address_generator.sv
// Bench for loop_address_generator: directed and random runs compared against an address list
// built from row/column arithmetic (base + row*stride + col, mod 2^16).
module tb_loop_address_generator;

    localparam int unsigned CW = 4;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          clear;
    logic          start;
    logic [CW-1:0] im_in, om_in;
    logic [AW-1:0] base_in, stride_in;
    logic          busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    loop_address_generator_if #(.AddrWidth(AW)) bus ();

    loop_address_generator #(
        .CounterWidth(CW),
        .AddrWidth   (AW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clear),
        .start_i     (start),
        .inner_max_i (im_in),
        .outer_max_i (om_in),
        .base_addr_i (base_in),
        .row_stride_i(stride_in),
        .busy_o      (busy),
        .done_o      (done),
        .addr_if     (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_cfg();
        im_in     = CW'($urandom);
        om_in     = CW'($urandom);
        base_in   = AW'($urandom);
        stride_in = AW'($urandom);
    endtask

    // mode: 0 ready always high, 1 ready pattern 1,0,0 repeating, 2 random ready.
    // clear_at: beat index at which Clear is raised (-1 for none).
    // noise: random Start pulses and config churn while the run is in flight.
    task automatic run_cfg(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [CW-1:0] im, input logic [CW-1:0] om,
                           input int mode, input int clear_at, input bit noise);
        logic [AW-1:0] q[$];
        int total, idx, cycles, phase;
        bit r;
        for (int j = 0; j <= int'(om); j++)
            for (int i = 0; i <= int'(im); i++)
                q.push_back(AW'(int'(base) + j * int'(stride) + i));
        total = q.size();

        @(negedge clk);
        base_in = base; stride_in = stride; im_in = im; om_in = om;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_cfg();

        idx = 0; cycles = 0; phase = 0;
        while (idx < total && cycles < 2000) begin
            check_eq("valid", 32'(bus.valid), 32'd1);
            check_eq("addr", 32'(bus.addr), 32'(q[idx]));
            check_eq("last", 32'(bus.last), 32'(idx == total - 1));
            check_eq("busy_run", 32'(busy), 32'd1);
            check_eq("done_run", 32'(done), 32'd0);
            if (idx == clear_at) begin
                clear = 1'b1;
                bus.ready = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                bus.ready = 1'b0;
                check_eq("clr_valid", 32'(bus.valid), 32'd0);
                check_eq("clr_busy", 32'(busy), 32'd0);
                check_eq("clr_done", 32'(done), 32'd0);
                @(negedge clk);
                check_eq("clr_done2", 32'(done), 32'd0);
                check_eq("clr_valid2", 32'(bus.valid), 32'd0);
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (phase % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            phase++;
            bus.ready = r;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                scramble_cfg();
            end
            @(negedge clk);
            if (r) idx++;
            cycles++;
        end

        if (idx < total) begin
            check_eq("timeout", 32'd0, 32'd1);
        end else begin
            check_eq("done_pulse", 32'(done), 32'd1);
            check_eq("done_valid", 32'(bus.valid), 32'd0);
            check_eq("done_busy", 32'(busy), 32'd1);
            start = noise;
            @(negedge clk);
            start = 1'b0;
            check_eq("post_done", 32'(done), 32'd0);
            check_eq("post_busy", 32'(busy), 32'd0);
            check_eq("post_valid", 32'(bus.valid), 32'd0);
        end
        bus.ready = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; clear = 1'b0; start = 1'b0; bus.ready = 1'b0;
        im_in = '0; om_in = '0; base_in = '0; stride_in = '0;
        #1;
        check_eq("rst_valid", 32'(bus.valid), 32'd0);
        check_eq("rst_addr", 32'(bus.addr), 32'd0);
        check_eq("rst_last", 32'(bus.last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        run_cfg(16'h0100, 16'h0010, 4'd2, 4'd1, 0, -1, 1'b0);
        run_cfg(16'h0100, 16'h0010, 4'd2, 4'd1, 1, -1, 1'b0);
        run_cfg(16'h0042, 16'h1234, 4'd0, 4'd0, 0, -1, 1'b1);
        run_cfg(16'hFFFE, 16'h0004, 4'd3, 4'd1, 0, -1, 1'b0);
        run_cfg(16'h0100, 16'h0010, 4'd2, 4'd1, 0, 2, 1'b0);
        run_cfg(16'h0100, 16'h0010, 4'd2, 4'd1, 0, -1, 1'b0);

        // Asynchronous reset mid-run, away from any clock edge.
        @(negedge clk);
        base_in = 16'h0200; stride_in = 16'h0020; im_in = 4'd3; om_in = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus.valid), 32'd0);
        check_eq("arst_addr", 32'(bus.addr), 32'd0);
        check_eq("arst_last", 32'(bus.last), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        bus.ready = 1'b0;
        @(negedge clk);
        check_eq("arst_idle_valid", 32'(bus.valid), 32'd0);
        check_eq("arst_idle_done", 32'(done), 32'd0);
        run_cfg(16'h0300, 16'h0008, 4'd1, 4'd2, 0, -1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            run_cfg(AW'($urandom), AW'($urandom), CW'($urandom_range(0, 15)),
                    CW'($urandom_range(0, 15)), 2, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/loop_address_generator.md
# loop_address_generator

Two-level nested-loop address generator that turns a tile shape (rows × columns) into a stream of linear memory addresses for the accelerator's buffer read/write ports. It sits directly downstream of the loop counters: it owns its inner (column) and outer (row) counters with the same inclusive 0..Max counting rule, and converts their values into addresses delivered over a valid/ready handshake to the memory-side consumer. One run is launched by a Start pulse and ends with a one-cycle Done pulse.

## Interface
- COUNTER_WIDTH, 4: width of loop indices and of InnerMax/OuterMax.
- ADDR_WIDTH, 16: width of BaseAddr, RowStride, Addr.

- CLK  input  1  clock; all state changes on rising edge.
- ASYNC_RST  input  1  asynchronous, active-low reset.
- Clear  input  1  synchronous abort; returns to IDLE next edge, no Done.
- Start  input  1  launch request; honoured only in IDLE.
- InnerMax  input  COUNTER_WIDTH  last column index (inclusive); sampled on accepted Start.
- OuterMax  input  COUNTER_WIDTH  last row index (inclusive); sampled on accepted Start.
- BaseAddr  input  ADDR_WIDTH  address of element (0,0); sampled on accepted Start.
- RowStride  input  ADDR_WIDTH  address delta between rows; sampled on accepted Start.
- AddrReady  input  1  consumer accepts current beat.
- AddrValid  output  1  Addr/Last are valid.
- Addr  output  ADDR_WIDTH  current address.
- Last  output  1  current beat is the final one of the run.
- Busy  output  1  high in RUN and DONE.
- Done  output  1  one-cycle pulse after final beat accepted.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: AddrValid=0, Busy=0. Start=1 → latch config, i=0, j=0, RowBase=BaseAddr, go RUN.
- RUN: AddrValid=1; Addr = RowBase + i (mod 2^ADDR_WIDTH); Last = (i==InnerMax && j==OuterMax).
- Handshake: beat transfers when AddrValid && AddrReady. Without transfer, Addr/Last/AddrValid hold stable. AddrValid never drops in RUN without a transfer.
- On transfer, not Last: if i==InnerMax → i=0, j=j+1, RowBase=RowBase+RowStride; else i=i+1.
- On transfer with Last → DONE.
- DONE: AddrValid=0, Busy=1, Done=1 for exactly one cycle, then IDLE.
- Start outside IDLE ignored; config inputs ignored outside the accepting Start cycle.
- Clear=1 in any state → IDLE next edge; Done not pulsed; Clear has priority over Start and over a simultaneous transfer.
- Address arithmetic unsigned, wraps modulo 2^ADDR_WIDTH; no multiplier (RowBase accumulated).
- InnerMax=0 and/or OuterMax=0 legal: single-column/single-row runs; both 0 → one beat with Last=1.
- Beats per run = (InnerMax+1)·(OuterMax+1).

## Timing
- Reset (ASYNC_RST=0, immediate, no clock): state IDLE; AddrValid=0, Addr=0, Last=0, Busy=0, Done=0; internal i, j, RowBase, latched config = 0. Reset mid-run discards the run, no Done.
- Start accepted at edge n → AddrValid=1, Addr=BaseAddr at cycle n+1.
- Throughput: one beat per cycle with AddrReady held high; no bubble at row wrap.
- Final beat transferred at edge m → Done=1 during cycle m+1 (DONE); IDLE at m+2; earliest next Start accepted at edge m+2.
- Outputs registered or derived only from registered state; no combinational path AddrReady → AddrValid/Addr.

## Test plan
- BaseAddr=0x0100, RowStride=0x0010, InnerMax=2, OuterMax=1, AddrReady=1 → Addr 0x0100,0x0101,0x0102,0x0110,0x0111,0x0112 on consecutive cycles, Last only on 0x0112, Done one cycle later.
- Same config, AddrReady toggled 1,0,0,1,... → each address held stable across stalls, same 6-address sequence, no duplicates or skips.
- InnerMax=0, OuterMax=0, BaseAddr=0x0042 → single beat 0x0042 with Last=1, Done next cycle; Start pulsed during RUN/DONE ignored.
- BaseAddr=0xFFFE, RowStride=0x0004, InnerMax=3, OuterMax=1 → 0xFFFE,0xFFFF,0x0000,0x0001,0x0002,0x0003,0x0004,0x0005 (wrap modulo 2^16).
- Clear asserted on 3rd beat with AddrReady=1 → IDLE next edge, AddrValid=0, no Done; new Start then restarts from BaseAddr.
- ASYNC_RST driven low mid-run between clock edges → all outputs 0 immediately; after release, IDLE awaiting Start.
